// File: rtl/axil_pkg.sv
// Shared types and helpers for the AXI-Lite write-data responder.
// beat_t is sized for the default data width.
package axil_pkg;

  localparam int AXI_DATA_WIDTH_DEF = 32;

  function automatic int strb_width(input int w);
    return w / 8;
  endfunction

  typedef struct packed {
    logic [AXI_DATA_WIDTH_DEF-1:0]   data;
    logic [AXI_DATA_WIDTH_DEF/8-1:0] strb;
  } beat_t;

endpackage

// File: rtl/axil_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; head shows the next beat, or the
// most recently popped beat while empty.
module axil_sync_fifo #(
  parameter  int WIDTH = 36,
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int PW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [PW-1:0]    level,
  output logic [PW-1:0]    level_next
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_idx, rd_idx, last_idx;
  logic             do_push, do_pop;

  assign wr_idx   = wr_ptr_q[AW-1:0];
  assign rd_idx   = rd_ptr_q[AW-1:0];
  assign last_idx = rd_idx - AW'(1);

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);
  assign level = wr_ptr_q - rd_ptr_q;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_idx] = push_data;
      wr_ptr_d      = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  assign level_next = wr_ptr_d - rd_ptr_d;

  // While empty, the slot just behind the read pointer is the last beat popped
  // and cannot have been overwritten, so the output holds steady.
  assign head_data = empty ? mem_q[last_idx] : mem_q[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/axil_wdata_slave.sv
// AXI-Lite W-channel responder: buffers beats into a FIFO toward the local
// register-write port and flags master stall/stability violations.
module axil_wdata_slave
  import axil_pkg::*;
#(
  parameter  int C_AXI_DATA_WIDTH = AXI_DATA_WIDTH_DEF,
  parameter  int DEPTH            = 2,
  parameter  int MAXWAIT          = 5,
  localparam int STRB_W           = strb_width(C_AXI_DATA_WIDTH),
  localparam int LVL_W            = $clog2(DEPTH) + 1
) (
  input  logic                        AXI_ACLK,
  input  logic                        AXI_ARESETN,
  input  logic [C_AXI_DATA_WIDTH-1:0] AXI_WDATA,
  input  logic [STRB_W-1:0]           AXI_WSTRB,
  input  logic                        AXI_WVALID,
  output logic                        AXI_WREADY,
  output logic [C_AXI_DATA_WIDTH-1:0] wr_data,
  output logic [STRB_W-1:0]           wr_strb,
  output logic                        wr_valid,
  input  logic                        wr_ready,
  output logic [LVL_W-1:0]            fill_level,
  output logic                        wait_err,
  output logic                        proto_err
);

  localparam int BEAT_W = C_AXI_DATA_WIDTH + STRB_W;
  localparam int SC_W   = $clog2(MAXWAIT + 1);

  // Handshakes: a beat moves on a rising edge where valid and ready are both
  // high; a source holding valid must keep its payload stable until it moves.
  logic                        push, pop;
  logic                        fifo_full, fifo_empty;
  logic [LVL_W-1:0]            level_next;
  logic [BEAT_W-1:0]           head;

  logic                        armed_q, armed_d;
  logic                        wready_q, wready_d;
  logic [SC_W-1:0]             stall_q, stall_d;
  logic                        wait_err_q, wait_err_d;
  logic                        proto_err_q, proto_err_d;
  logic                        prev_valid_q, prev_valid_d;
  logic                        prev_ready_q, prev_ready_d;
  logic [C_AXI_DATA_WIDTH-1:0] prev_data_q, prev_data_d;
  logic [STRB_W-1:0]           prev_strb_q, prev_strb_d;

  assign push = AXI_WVALID & wready_q & ~fifo_full;
  assign pop  = wr_valid & wr_ready;

  axil_sync_fifo #(
    .WIDTH (BEAT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (AXI_ACLK),
    .rst_n      (AXI_ARESETN),
    .push       (push),
    .push_data  ({AXI_WDATA, AXI_WSTRB}),
    .pop        (pop),
    .head_data  (head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .level      (fill_level),
    .level_next (level_next)
  );

  always_comb begin
    armed_d = 1'b1;
    // Ready follows next-cycle occupancy so a filling push drops it at once.
    wready_d = armed_q & (level_next < LVL_W'(DEPTH));

    stall_d = '0;
    if (AXI_WVALID && !wready_q) begin
      stall_d = (stall_q == SC_W'(MAXWAIT)) ? stall_q : stall_q + SC_W'(1);
    end
    wait_err_d = wait_err_q | (stall_d == SC_W'(MAXWAIT));

    prev_valid_d = AXI_WVALID;
    prev_ready_d = wready_q;
    prev_data_d  = AXI_WDATA;
    prev_strb_d  = AXI_WSTRB;
    proto_err_d  = proto_err_q;
    if (armed_q && prev_valid_q && !prev_ready_q) begin
      if (!AXI_WVALID || (AXI_WDATA != prev_data_q) || (AXI_WSTRB != prev_strb_q)) begin
        proto_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      armed_q      <= 1'b0;
      wready_q     <= 1'b0;
      stall_q      <= '0;
      wait_err_q   <= 1'b0;
      proto_err_q  <= 1'b0;
      prev_valid_q <= 1'b0;
      prev_ready_q <= 1'b0;
      prev_data_q  <= '0;
      prev_strb_q  <= '0;
    end else begin
      armed_q      <= armed_d;
      wready_q     <= wready_d;
      stall_q      <= stall_d;
      wait_err_q   <= wait_err_d;
      proto_err_q  <= proto_err_d;
      prev_valid_q <= prev_valid_d;
      prev_ready_q <= prev_ready_d;
      prev_data_q  <= prev_data_d;
      prev_strb_q  <= prev_strb_d;
    end
  end

  assign AXI_WREADY = wready_q;
  assign wr_valid   = ~fifo_empty;
  assign wr_data    = head[BEAT_W-1:STRB_W];
  assign wr_strb    = head[STRB_W-1:0];
  assign wait_err   = wait_err_q;
  assign proto_err  = proto_err_q;

endmodule
